// File: rtl/mat_mul_pkg.sv
// Shared constants and types for the 8x8 matrix-multiply unit and its operand loader.
package mat_mul_pkg;

  localparam int W_IN  = 8;
  localparam int N     = 8;
  localparam int W_OUT = 2 * W_IN + $clog2(N);

  typedef logic signed [W_IN-1:0] elem_t;
  typedef elem_t [N-1:0]          row_t;
  typedef row_t  [N-1:0]          mat_t;

  typedef enum logic {
    LOAD_A,
    LOAD_B
  } loader_state_e;

endpackage

// File: rtl/mat_mul_loader.sv
// Operand loader: assembles N rows of A then N rows of B from a valid/ready stream,
// publishes both matrices with a one-cycle valid pulse. MAT_LOADER_TRANSPOSE_B_EN: B beats are columns.
module mat_mul_loader
  import mat_mul_pkg::*;
#(
  parameter int W_IN = mat_mul_pkg::W_IN,
  parameter int N    = mat_mul_pkg::N
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                cen,
  input  logic                                s_valid,
  output logic                                s_ready,
  input  logic [N*W_IN-1:0]                   s_data,
  input  logic                                s_last,
  output logic                                valid_out,
  output logic [N-1:0][N-1:0][W_IN-1:0]       matrix_1,
  output logic [N-1:0][N-1:0][W_IN-1:0]       matrix_2,
  output logic                                err,
  input  logic                                err_clr
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  loader_state_e                  state_q, state_d;
  logic [CW-1:0]                  row_cnt_q, row_cnt_d;
  logic                           ready_q, ready_d;
  logic                           valid_q, valid_d;
  logic                           err_q, err_d;
  logic [N-1:0][N-1:0][W_IN-1:0]  stage_a_q, stage_a_d;
  logic [N-1:0][N-1:0][W_IN-1:0]  stage_b_q, stage_b_d;
  logic [N-1:0][N-1:0][W_IN-1:0]  mat1_q, mat1_d;
  logic [N-1:0][N-1:0][W_IN-1:0]  mat2_q, mat2_d;

  logic [N-1:0][W_IN-1:0]         row;
  logic                           accept;
  logic                           last_row;

  for (genvar j = 0; j < N; j++) begin : g_unpack
    assign row[j] = s_data[j*W_IN +: W_IN];
  end

  assign s_ready   = ready_q & cen;
  assign valid_out = valid_q & cen;
  assign err       = err_q;
  assign matrix_1  = mat1_q;
  assign matrix_2  = mat2_q;

  assign accept   = s_valid & s_ready;
  assign last_row = (state_q == LOAD_B) && (row_cnt_q == CW'(N - 1));

  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    ready_d   = ready_q;
    valid_d   = valid_q;
    err_d     = err_q;
    stage_a_d = stage_a_q;
    stage_b_d = stage_b_q;
    mat1_d    = mat1_q;
    mat2_d    = mat2_q;

    if (cen) begin
      ready_d = 1'b1;
      valid_d = 1'b0;
      if (err_clr) err_d = 1'b0;

      if (accept) begin
        // Framing error: s_last must appear exactly on the final B row; the beat is dropped.
        if (s_last != last_row) begin
          err_d     = 1'b1;
          state_d   = LOAD_A;
          row_cnt_d = '0;
        end else begin
          if (state_q == LOAD_A) begin
            stage_a_d[row_cnt_q] = row;
          end else begin
`ifdef MAT_LOADER_TRANSPOSE_B_EN
            for (int unsigned j = 0; j < N; j++) begin
              stage_b_d[j][row_cnt_q] = row[j];
            end
`else
            stage_b_d[row_cnt_q] = row;
`endif
          end

          if (row_cnt_q == CW'(N - 1)) begin
            row_cnt_d = '0;
            state_d   = (state_q == LOAD_A) ? LOAD_B : LOAD_A;
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end

          // Copy uses the _d staging so the final B row lands in the same edge.
          if (last_row) begin
            mat1_d  = stage_a_d;
            mat2_d  = stage_b_d;
            valid_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= LOAD_A;
      row_cnt_q <= '0;
      ready_q   <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      stage_a_q <= '0;
      stage_b_q <= '0;
      mat1_q    <= '0;
      mat2_q    <= '0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      stage_a_q <= stage_a_d;
      stage_b_q <= stage_b_d;
      mat1_q    <= mat1_d;
      mat2_q    <= mat2_d;
    end
  end

endmodule

// File: tb/tb_mat_mul_loader.sv
// Self-checking bench for mat_mul_loader: beat-list reference model plus directed scenarios.
module tb_mat_mul_loader;

  logic                   clk = 1'b0;
  logic                   rstn;
  logic                   cen;
  logic                   s_valid;
  logic                   s_ready;
  logic [63:0]            s_data;
  logic                   s_last;
  logic                   valid_out;
  logic [7:0][7:0][7:0]   matrix_1;
  logic [7:0][7:0][7:0]   matrix_2;
  logic                   err;
  logic                   err_clr;

  int tests_run = 0;
  int tests_failed = 0;

  mat_mul_loader #(.W_IN(8), .N(8)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .cen       (cen),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .valid_out (valid_out),
    .matrix_1  (matrix_1),
    .matrix_2  (matrix_2),
    .err       (err),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: collect accepted beats; a pair is 16 beats with s_last only on the 16th.
  logic [63:0]          pend[$];
  logic                 m_rdy = 1'b0;
  logic                 m_valid = 1'b0;
  logic                 m_err = 1'b0;
  logic                 m_took = 1'b0;
  logic [7:0][7:0][7:0] m_m1 = '0;
  logic [7:0][7:0][7:0] m_m2 = '0;

  always @(posedge clk or negedge rstn) begin
    logic acc;
    if (!rstn) begin
      m_rdy = 1'b0; m_valid = 1'b0; m_err = 1'b0; m_took = 1'b0;
      m_m1 = '0; m_m2 = '0;
      pend.delete();
    end else begin
      m_took = 1'b0;
      if (cen) begin
        acc = s_valid && m_rdy;
        m_valid = 1'b0;
        if (err_clr) m_err = 1'b0;
        if (acc) begin
          m_took = 1'b1;
          if ((s_last === 1'b1) != (pend.size() == 15)) begin
            m_err = 1'b1;
            pend.delete();
          end else begin
            pend.push_back(s_data);
            if (pend.size() == 16) begin
              for (int r = 0; r < 8; r++) begin
                for (int j = 0; j < 8; j++) begin
                  m_m1[r][j] = pend[r][j*8 +: 8];
`ifdef MAT_LOADER_TRANSPOSE_B_EN
                  m_m2[j][r] = pend[8+r][j*8 +: 8];
`else
                  m_m2[r][j] = pend[8+r][j*8 +: 8];
`endif
                end
              end
              m_valid = 1'b1;
              pend.delete();
            end
          end
        end
        m_rdy = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    chk("ready", s_ready, m_rdy & cen);
    chk("valid", valid_out, m_valid & cen);
    chk("err", err, m_err);
    chk("matrix_1", matrix_1, m_m1);
    chk("matrix_2", matrix_2, m_m2);
  end

  int  vcount = 0;
  time vtimes[$];
  always @(negedge clk) begin
    if (valid_out === 1'b1) begin
      vcount++;
      vtimes.push_back($time);
    end
  end

  function automatic logic [63:0] gen(input int kind, input int p, input int b);
    logic [63:0] d;
    int r;
    r = b - 8;
    for (int j = 0; j < 8; j++) begin
      case (kind)
        0:       d[j*8 +: 8] = (b < 8) ? ((b == j) ? 8'd1 : 8'd0) : 8'(r * 8 + j);
        1:       d[j*8 +: 8] = 8'(p * 128 + b * 8 + j);
        default: d[j*8 +: 8] = (b < 8) ? 8'(b + j) : 8'(r);
      endcase
    end
    return d;
  endfunction

  task automatic send_beat(input logic [63:0] d, input logic last);
    int n;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!m_took && n < 20);
    chk("beat_taken", m_took, 1'b1);
  endtask

  task automatic send_beats(input int kind, input int p, input int first, input int last_b);
    for (int b = first; b <= last_b; b++) send_beat(gen(kind, p, b), b == 15);
  endtask

  initial begin
    rstn = 1'b0; cen = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; err_clr = 1'b0;
    #12;
    chk("rst_ready", s_ready, 1'b0);
    chk("rst_valid", valid_out, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_m1", matrix_1, '0);
    @(posedge clk); #1 rstn = 1'b1;
    #1 chk("ready_after_release", s_ready, 1'b0);
    @(posedge clk); #1;
    chk("ready_rises", s_ready, 1'b1);

    // identity A, B[i][j] = i*8+j
    send_beats(0, 0, 0, 15);
    chk("t1_valid_latency", valid_out, 1'b1);
    chk("t1_m1_22", matrix_1[2][2], 8'd1);
    chk("t1_m1_23", matrix_1[2][3], 8'd0);
    chk("t1_m2_35", matrix_2[3][5], 8'd29);
    chk("t1_m2_77", matrix_2[7][7], 8'd63);
    chk("t1_err", err, 1'b0);
    s_valid = 1'b0;
    @(posedge clk); #1;
    chk("t1_valid_pulse_end", valid_out, 1'b0);

    // three back-to-back pairs sweeping the full signed range
    vcount = 0; vtimes.delete();
    for (int p = 0; p < 3; p++) begin
      send_beats(1, p, 0, 15);
      if (p == 0) chk("t2_m2_77_7f", matrix_2[7][7], 8'h7f);
      if (p == 1) chk("t2_m1_00_neg128", 32'($signed(matrix_1[0][0])), 32'(-128));
    end
    s_valid = 1'b0;
    @(posedge clk); #1;
    chk("t2_pulses", vcount, 3);
    chk("t2_gap01", vtimes[1] - vtimes[0], 160);
    chk("t2_gap12", vtimes[2] - vtimes[1], 160);

    // framing error on beat 5, then a clean pair, then clear
    send_beats(1, 1, 0, 4);
    send_beat(gen(1, 1, 5), 1'b1);
    chk("t3_err_set", err, 1'b1);
    send_beats(1, 1, 0, 15);
    chk("t3_valid", valid_out, 1'b1);
    chk("t3_m1_00", matrix_1[0][0], 8'h80);
    chk("t3_err_sticky", err, 1'b1);
    s_valid = 1'b0;
    err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    chk("t3_err_clr", err, 1'b0);
    err_clr = 1'b1;
    send_beat(gen(1, 0, 0), 1'b1);
    err_clr = 1'b0;
    chk("t3_set_wins", err, 1'b1);

    // clock-enable stall in the middle of B
    send_beats(1, 2, 0, 10);
    s_data = gen(1, 2, 11); s_last = 1'b0; s_valid = 1'b1;
    cen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("t4_ready_frozen", s_ready, 1'b0);
      chk("t4_no_take", m_took, 1'b0);
    end
    cen = 1'b1;
    send_beats(1, 2, 11, 15);
    chk("t4_valid", valid_out, 1'b1);
    chk("t4_m2_30", matrix_2[3][0], 8'd88);
    s_valid = 1'b0;

    // asynchronous reset mid-pair
    send_beats(2, 0, 0, 8);
    s_valid = 1'b0;
    @(posedge clk); #3 rstn = 1'b0;
    #1;
    chk("t5_valid0", valid_out, 1'b0);
    chk("t5_err0", err, 1'b0);
    chk("t5_ready0", s_ready, 1'b0);
    chk("t5_m1_0", matrix_1, '0);
    chk("t5_m2_0", matrix_2, '0);
    @(posedge clk); #1 rstn = 1'b1;
    send_beats(2, 0, 0, 15);
    chk("t5_valid", valid_out, 1'b1);
    chk("t5_m1_34", matrix_1[3][4], 8'd7);
`ifdef MAT_LOADER_TRANSPOSE_B_EN
    chk("t6_m2_25", matrix_2[2][5], 8'd5);
    chk("t6_m2_70", matrix_2[7][0], 8'd0);
`else
    chk("t6_m2_25", matrix_2[2][5], 8'd2);
    chk("t6_m2_70", matrix_2[7][0], 8'd7);
`endif
    s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
